// File: rtl/galaga_countdown_if.sv
// galaga_countdown_if: control, preset and display signals of the countdown timer
interface galaga_countdown_if;
  logic       i_fStartStop;
  logic       i_fLoad;
  logic [3:0] i_Preset0;
  logic [3:0] i_Preset1;
  logic [3:0] i_Preset2;
  logic [3:0] o_Bcd0;
  logic [3:0] o_Bcd1;
  logic [3:0] o_Bcd2;
  logic [6:0] o_Sec0;
  logic [6:0] o_Sec1;
  logic [6:0] o_Sec2;
  logic       o_fRun;
  logic       o_fTimeUp;
  modport master (
    output i_fStartStop, i_fLoad, i_Preset0, i_Preset1, i_Preset2,
    input  o_Bcd0, o_Bcd1, o_Bcd2, o_Sec0, o_Sec1, o_Sec2, o_fRun, o_fTimeUp
  );
  modport slave (
    input  i_fStartStop, i_fLoad, i_Preset0, i_Preset1, i_Preset2,
    output o_Bcd0, o_Bcd1, o_Bcd2, o_Sec0, o_Sec1, o_Sec2, o_fRun, o_fTimeUp
  );
endinterface

// File: rtl/galaga_countdown.sv
// galaga_countdown: 3-digit BCD countdown timer with start/stop toggle, time-up flag and 7-segment outputs
module galaga_countdown #(
  parameter int LST_CLK = 4_999_999
) (
  input logic                i_Clk,
  input logic                i_Rst,
  galaga_countdown_if.slave  bus
);
  localparam int CW = LST_CLK > 0 ? $clog2(LST_CLK + 1) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t c_State, n_State;
  logic [3:0] c_Sec0, c_Sec1, c_Sec2, n_Sec0, n_Sec1, n_Sec2, d_Sec0, d_Sec1, d_Sec2;
  logic [CW-1:0] c_ClkCnt, n_ClkCnt;
  logic c_fStartStopD, fPress, fTick, fZero, fDecZero;
  function automatic logic [3:0] clamp(input logic [3:0] v);
    return v > 4'd9 ? 4'd9 : v;
  endfunction
  function automatic logic [6:0] fnd(input logic [3:0] d);
    case (d)
      4'd0: fnd = 7'h3F;
      4'd1: fnd = 7'h06;
      4'd2: fnd = 7'h5B;
      4'd3: fnd = 7'h4F;
      4'd4: fnd = 7'h66;
      4'd5: fnd = 7'h6D;
      4'd6: fnd = 7'h7D;
      4'd7: fnd = 7'h07;
      4'd8: fnd = 7'h7F;
      4'd9: fnd = 7'h6F;
      default: fnd = 7'h00;
    endcase
  endfunction
  assign fPress   = bus.i_fStartStop & ~c_fStartStopD;
  assign fTick    = c_ClkCnt == CW'(LST_CLK);
  assign fZero    = {c_Sec2, c_Sec1, c_Sec0} == 12'd0;
  assign d_Sec0   = c_Sec0 == 4'd0 ? 4'd9 : c_Sec0 - 4'd1;
  assign d_Sec1   = c_Sec0 != 4'd0 ? c_Sec1 : c_Sec1 == 4'd0 ? 4'd9 : c_Sec1 - 4'd1;
  assign d_Sec2   = (c_Sec0 == 4'd0 && c_Sec1 == 4'd0) ? c_Sec2 - 4'd1 : c_Sec2;
  assign fDecZero = {d_Sec2, d_Sec1, d_Sec0} == 12'd0;
  always_comb begin
    n_State  = c_State;
    n_Sec0   = c_Sec0;
    n_Sec1   = c_Sec1;
    n_Sec2   = c_Sec2;
    n_ClkCnt = c_ClkCnt;
    if (bus.i_fLoad && c_State != RUN) begin
      n_Sec0   = clamp(bus.i_Preset0);
      n_Sec1   = clamp(bus.i_Preset1);
      n_Sec2   = clamp(bus.i_Preset2);
      n_ClkCnt = '0;
      n_State  = IDLE;
    end else begin
      case (c_State)
        IDLE:  if (fPress) n_State = fZero ? DONE : RUN;
        RUN: begin
          n_ClkCnt = fTick ? '0 : c_ClkCnt + 1'b1;
          if (fPress) n_State = PAUSE;
          if (fTick && !fZero) begin
            n_Sec0 = d_Sec0;
            n_Sec1 = d_Sec1;
            n_Sec2 = d_Sec2;
            if (fDecZero) n_State = DONE;
          end
        end
        PAUSE: if (fPress) n_State = RUN;
        default: ;
      endcase
    end
  end
  // The button sampler also runs during reset so a button held through reset is not seen as a press.
  always_ff @(posedge i_Clk) begin
    c_fStartStopD <= bus.i_fStartStop;
    if (i_Rst) begin
      c_State  <= IDLE;
      c_Sec0   <= '0;
      c_Sec1   <= '0;
      c_Sec2   <= '0;
      c_ClkCnt <= '0;
    end else begin
      c_State  <= n_State;
      c_Sec0   <= n_Sec0;
      c_Sec1   <= n_Sec1;
      c_Sec2   <= n_Sec2;
      c_ClkCnt <= n_ClkCnt;
    end
  end
  assign bus.o_Bcd0    = c_Sec0;
  assign bus.o_Bcd1    = c_Sec1;
  assign bus.o_Bcd2    = c_Sec2;
  assign bus.o_Sec0    = fnd(c_Sec0);
  assign bus.o_Sec1    = fnd(c_Sec1);
  assign bus.o_Sec2    = fnd(c_Sec2);
  assign bus.o_fRun    = c_State == RUN;
  assign bus.o_fTimeUp = c_State == DONE;
endmodule
